// File: rtl/j_clkdiv_multi_pkg.sv
// Shared definitions for the multi-channel programmable clock divider:
// synchroniser depths, the reset divide value and the legacy channel slots.
package j_clkdiv_multi_pkg;

    localparam int SYNC_NONE = 0;
    localparam int SYNC_TWO  = 2;

    // Reload of 1 divides by two, matching the old fixed dividers at power-up.
    localparam int DEFAULT_RESET_DIV = 1;

    localparam int CH_PCLK = 0;
    localparam int CH_VCLK = 1;
    localparam int CH_CHR  = 2;

    // Any depth other than the two supported ones collapses to "no synchroniser".
    function automatic int sync_depth(input int stages);
        return (stages == SYNC_TWO) ? SYNC_TWO : SYNC_NONE;
    endfunction

endpackage

// File: rtl/j_clkdiv_multi_if.sv
// Host write bus and divider outputs of j_clkdiv_multi, grouped as one interface.
interface j_clkdiv_multi_if #(
    parameter int NCH = 3,
    parameter int W   = 10
);

    logic [NCH-1:0]   wr_en;
    logic [W-1:0]     din;
    logic             din_en;
    logic             din_restart;
    logic [NCH-1:0]   div_pulse;
    logic [NCH-1:0]   div_sq;
    logic [NCH*W-1:0] cnt_q;

    modport master (
        output wr_en, din, din_en, din_restart,
        input  div_pulse, div_sq, cnt_q
    );

    modport slave (
        input  wr_en, din, din_en, din_restart,
        output div_pulse, div_sq, cnt_q
    );

endinterface

// File: rtl/j_clkdiv_chan.sv
// One divider channel: optional synchroniser, rising-edge detect, reload register,
// down-counter, terminal pulse and square output.
module j_clkdiv_chan
    import j_clkdiv_multi_pkg::*;
#(
    parameter int W           = 10,
    parameter int RESET_DIV   = DEFAULT_RESET_DIV,
    parameter int SYNC_STAGES = SYNC_NONE
) (
    input  logic         sys_clk,
    input  logic         resetl,
    input  logic         clk_in,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         din_en,
    input  logic         din_restart,
    output logic         div_pulse,
    output logic         div_sq,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] RESET_RELOAD = W'(RESET_DIV);

    logic         src;
    logic         src_q, src_d;
    logic         tick;
    logic [W-1:0] reload_q, reload_d;
    logic         en_q, en_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         pulse_q, pulse_d;
    logic         sq_q, sq_d;

    // Synchroniser flops reset high so a source already high at release is not an edge.
    generate
        if (sync_depth(SYNC_STAGES) == SYNC_TWO) begin : g_sync
            logic [1:0] sync_q, sync_d;

            always_comb begin
                sync_d = {sync_q[0], clk_in};
            end

            always_ff @(posedge sys_clk or negedge resetl) begin
                if (!resetl) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign src = sync_q[1];
        end else begin : g_nosync
            assign src = clk_in;
        end
    endgenerate

    assign tick = src & ~src_q;

    always_comb begin
        src_d    = src;
        reload_d = reload_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        sq_d     = sq_q;

        // A restart write drops a coincident tick; a plain write lets the tick use the old reload.
        if (wr_en && din_restart) begin
            cnt_d = din;
            sq_d  = 1'b0;
        end else if (en_q && tick) begin
            if (cnt_q == '0) begin
                cnt_d   = reload_q;
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            sq_d = (cnt_d > (reload_q >> 1));
        end

        if (wr_en) begin
            reload_d = din;
            en_d     = din_en;
        end
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            src_q    <= 1'b1;
            reload_q <= RESET_RELOAD;
            en_q     <= 1'b1;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            src_q    <= src_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            sq_q     <= sq_d;
        end
    end

    assign div_pulse = pulse_q;
    assign div_sq    = sq_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/j_clkdiv_multi.sv
// N-channel programmable clock divider: fans the host write bus out to independent
// channels and packs their counters into one readback vector.
module j_clkdiv_multi
    import j_clkdiv_multi_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int W           = 10,
    parameter int RESET_DIV   = DEFAULT_RESET_DIV,
    parameter int SYNC_STAGES = SYNC_NONE
) (
    input  logic           sys_clk,
    input  logic           resetl,
    input  logic [NCH-1:0] clk_in,
    j_clkdiv_multi_if.slave bus
);

    logic [NCH-1:0]   pulse_w;
    logic [NCH-1:0]   sq_w;
    logic [NCH*W-1:0] cnt_w;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            j_clkdiv_chan #(
                .W           (W),
                .RESET_DIV   (RESET_DIV),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_chan (
                .sys_clk     (sys_clk),
                .resetl      (resetl),
                .clk_in      (clk_in[i]),
                .wr_en       (bus.wr_en[i]),
                .din         (bus.din),
                .din_en      (bus.din_en),
                .din_restart (bus.din_restart),
                .div_pulse   (pulse_w[i]),
                .div_sq      (sq_w[i]),
                .cnt         (cnt_w[i*W +: W])
            );
        end
    endgenerate

    assign bus.div_pulse = pulse_w;
    assign bus.div_sq    = sq_w;
    assign bus.cnt_q     = cnt_w;

endmodule

// File: tb/tb_j_clkdiv_multi.sv
// Randomised bench for j_clkdiv_multi: a direct-sampling and a 2-stage-synchronised
// instance share the stimulus and are checked every cycle against a tick-level model.
module tb_j_clkdiv_multi;
    import j_clkdiv_multi_pkg::*;

    localparam int NCH = 3;
    localparam int W   = 10;

    logic           sys_clk;
    logic           resetl;
    logic [NCH-1:0] clk_in;
    logic [NCH-1:0] wr_en;
    logic [W-1:0]   din;
    logic           din_en;
    logic           din_restart;

    int n_checks;
    int n_fail;
    int cyc;

    j_clkdiv_multi_if #(.NCH(NCH), .W(W)) bus0 ();
    j_clkdiv_multi_if #(.NCH(NCH), .W(W)) bus1 ();

    assign bus0.wr_en       = wr_en;
    assign bus0.din         = din;
    assign bus0.din_en      = din_en;
    assign bus0.din_restart = din_restart;
    assign bus1.wr_en       = wr_en;
    assign bus1.din         = din;
    assign bus1.din_en      = din_en;
    assign bus1.din_restart = din_restart;

    j_clkdiv_multi #(.NCH(NCH), .W(W), .RESET_DIV(1), .SYNC_STAGES(SYNC_NONE)) dut0 (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .clk_in  (clk_in),
        .bus     (bus0)
    );

    j_clkdiv_multi #(.NCH(NCH), .W(W), .RESET_DIV(1), .SYNC_STAGES(SYNC_TWO)) dut1 (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .clk_in  (clk_in),
        .bus     (bus1)
    );

    logic [NCH-1:0]   pulse_o [2];
    logic [NCH-1:0]   sq_o    [2];
    logic [NCH*W-1:0] cnt_o   [2];

    assign pulse_o[0] = bus0.div_pulse;
    assign pulse_o[1] = bus1.div_pulse;
    assign sq_o[0]    = bus0.div_sq;
    assign sq_o[1]    = bus1.div_sq;
    assign cnt_o[0]   = bus0.cnt_q;
    assign cnt_o[1]   = bus1.cnt_q;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model state, one set per instance; history holds raw clk_in samples,
    // newest in bit 0, so instance d sees its source delayed by its synchroniser depth.
    int       m_reload [2][NCH];
    bit       m_en     [2][NCH];
    int       m_cnt    [2][NCH];
    bit       m_pulse  [2][NCH];
    bit       m_sq     [2][NCH];
    bit [3:0] m_hist   [2][NCH];

    int half_per [NCH];
    int phase    [NCH];

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_reload[d][ch] = 1;
                m_en[d][ch]     = 1'b1;
                m_cnt[d][ch]    = 0;
                m_pulse[d][ch]  = 1'b0;
                m_sq[d][ch]     = 1'b0;
                m_hist[d][ch]   = 4'hF;
            end
        end
    endtask

    task automatic model_step();
        int  delay;
        bit  tick;
        if (!resetl) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            delay = (d == 0) ? 0 : 2;
            for (int ch = 0; ch < NCH; ch++) begin
                m_hist[d][ch] = {m_hist[d][ch][2:0], clk_in[ch]};
                tick = m_hist[d][ch][delay] && !m_hist[d][ch][delay+1];
                m_pulse[d][ch] = 1'b0;
                if (wr_en[ch] && din_restart) begin
                    m_cnt[d][ch] = int'(din);
                    m_sq[d][ch]  = 1'b0;
                end else if (m_en[d][ch] && tick) begin
                    if (m_cnt[d][ch] == 0) begin
                        m_cnt[d][ch]   = m_reload[d][ch];
                        m_pulse[d][ch] = 1'b1;
                    end else begin
                        m_cnt[d][ch] = m_cnt[d][ch] - 1;
                    end
                    m_sq[d][ch] = (m_cnt[d][ch] > m_reload[d][ch] / 2);
                end
                if (wr_en[ch]) begin
                    m_reload[d][ch] = int'(din);
                    m_en[d][ch]     = din_en;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                checkOutput($sformatf("d%0d_pulse%0d", d, ch), int'(pulse_o[d][ch]), int'(m_pulse[d][ch]));
                checkOutput($sformatf("d%0d_sq%0d", d, ch), int'(sq_o[d][ch]), int'(m_sq[d][ch]));
                checkOutput($sformatf("d%0d_cnt%0d", d, ch), int'(cnt_o[d][ch*W +: W]), m_cnt[d][ch]);
            end
        end
    endtask

    // One sys_clk cycle: drive at the falling edge, step the model on the rising edge, compare just after.
    task automatic applyStimulus(input logic [NCH-1:0] we, input logic [W-1:0] d,
                                 input logic de, input logic dr);
        @(negedge sys_clk);
        for (int ch = 0; ch < NCH; ch++) begin
            if (half_per[ch] != 0) begin
                phase[ch]++;
                if (phase[ch] >= half_per[ch]) begin
                    clk_in[ch] = ~clk_in[ch];
                    phase[ch]  = 0;
                end
            end
        end
        wr_en       = we;
        din         = d;
        din_en      = de;
        din_restart = dr;
        @(posedge sys_clk);
        model_step();
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus('0, '0, 1'b0, 1'b0);
        end
    endtask

    int first_p [2];
    int second_p[2];
    int sq_high [2];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        resetl      = 1'b0;
        clk_in      = '1;
        wr_en       = '0;
        din         = '0;
        din_en      = 1'b0;
        din_restart = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            half_per[ch] = 0;
            phase[ch]    = 0;
        end
        model_reset();

        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("rst_cnt0", int'(cnt_o[0]), 0);
        checkOutput("rst_cnt1", int'(cnt_o[1]), 0);
        checkOutput("rst_pulse0", int'(pulse_o[0]), 0);
        checkOutput("rst_sq1", int'(sq_o[1]), 0);
        @(negedge sys_clk);
        resetl = 1'b1;

        $display("[TB] reset release with sources held high");
        idle(4);

        $display("[TB] pclk channel reload 3, source period 8");
        half_per[CH_PCLK] = 4;
        applyStimulus(3'b001, 10'd3, 1'b1, 1'b1);
        for (int d = 0; d < 2; d++) begin
            first_p[d]  = -1;
            second_p[d] = -1;
            sq_high[d]  = 0;
        end
        for (int k = 0; k < 120; k++) begin
            applyStimulus('0, '0, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                if (pulse_o[d][CH_PCLK]) begin
                    if (first_p[d] < 0) first_p[d] = cyc;
                    else if (second_p[d] < 0) second_p[d] = cyc;
                end
                if (first_p[d] >= 0 && second_p[d] < 0 && sq_o[d][CH_PCLK]) sq_high[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("period_d%0d", d), second_p[d] - first_p[d], 32);
            checkOutput($sformatf("sq_high_d%0d", d), sq_high[d], 16);
        end

        $display("[TB] vclk channel reload 0 then 4");
        half_per[CH_VCLK] = 2;
        applyStimulus(3'b010, 10'd0, 1'b1, 1'b0);
        idle(40);
        applyStimulus(3'b010, 10'd4, 1'b1, 1'b0);
        idle(60);

        $display("[TB] chr channel restart write coincident with a tick");
        clk_in[CH_CHR] = 1'b0;
        idle(2);
        clk_in[CH_CHR] = 1'b1;
        applyStimulus(3'b100, 10'd5, 1'b1, 1'b1);
        checkOutput("restart_cnt_d0", int'(cnt_o[0][CH_CHR*W +: W]), 5);
        checkOutput("restart_pulse_d0", int'(pulse_o[0][CH_CHR]), 0);
        half_per[CH_CHR] = 3;
        idle(60);

        $display("[TB] non-restart write and enable toggling");
        applyStimulus(3'b001, 10'd7, 1'b1, 1'b0);
        idle(80);
        applyStimulus(3'b010, 10'd4, 1'b0, 1'b0);
        idle(30);
        applyStimulus(3'b010, 10'd4, 1'b1, 1'b0);
        idle(30);

        $display("[TB] random phase");
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 40) == 0) begin
                half_per[$urandom_range(0, NCH-1)] = $urandom_range(1, 7);
            end
            if (k == 1500) begin
                #2;
                resetl = 1'b0;
                #1;
                checkOutput("async_cnt0", int'(cnt_o[0]), 0);
                checkOutput("async_cnt1", int'(cnt_o[1]), 0);
                checkOutput("async_sq0", int'(sq_o[0]), 0);
                model_reset();
                idle(1);
                resetl = 1'b1;
            end
            if ($urandom_range(0, 11) == 0) begin
                applyStimulus(NCH'($urandom_range(1, 7)),
                              ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 1023)) : W'($urandom_range(0, 9)),
                              ($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 1)));
            end else begin
                applyStimulus('0, '0, 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
